// File: rtl/eca_engine.sv
// Elementary cellular-automaton row engine: any Wolfram rule, selectable boundary, runs N generations or until stable.
// One generation per clock in RUN; no backpressure, q is always valid and outputs move only on clk edges.
module eca_engine #(
    parameter int WIDTH = 512,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic [7:0]       rule,
    input  logic [1:0]       bound,
    input  logic [CNT_W-1:0] gen_target,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             stable,
    output logic [CNT_W-1:0] gens
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] row_q;
    logic [WIDTH-1:0] row_d;
    logic [CNT_W-1:0] gens_q;
    logic [CNT_W-1:0] gens_d;
    logic [CNT_W-1:0] target_q;
    logic [7:0]       rule_q;
    logic [1:0]       bound_q;
    logic             busy_q;
    logic             done_q;
    logic             stable_q;

    logic             edge_l;
    logic             edge_r;
    logic [WIDTH+1:0] ext_row;

    // Neighbours beyond the row ends: edge_l is L of the top cell, edge_r is R of cell 0.
    always_comb begin
        edge_l = 1'b0;
        edge_r = 1'b0;
        case (bound_q)
            2'd1: begin
                edge_l = row_q[0];
                edge_r = row_q[WIDTH-1];
            end
            2'd2: begin
                edge_l = 1'b1;
                edge_r = 1'b1;
            end
            default: begin
                edge_l = 1'b0;
                edge_r = 1'b0;
            end
        endcase
    end

    assign ext_row = {edge_l, row_q, edge_r};

    // ext_row[i +: 3] is {L, C, R} for cell i, which directly indexes the rule byte.
    always_comb begin
        row_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            row_d[i] = rule_q[ext_row[i +: 3]];
        end
    end

    assign gens_d = gens_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            gens_q   <= '0;
            target_q <= '0;
            rule_q   <= '0;
            bound_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            stable_q <= 1'b0;
        end else if (load) begin
            state_q  <= S_IDLE;
            row_q    <= data;
            gens_q   <= '0;
            stable_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (abort && state_q == S_RUN) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (start && state_q != S_RUN) begin
            rule_q   <= rule;
            bound_q  <= bound;
            target_q <= gen_target;
            gens_q   <= '0;
            stable_q <= 1'b0;
            if (gen_target == '0) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end else begin
                state_q <= S_RUN;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
            end
        end else if (state_q == S_RUN) begin
            if (row_d == row_q) begin
                state_q  <= S_DONE;
                stable_q <= 1'b1;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
            end else begin
                row_q  <= row_d;
                gens_q <= gens_d;
                if (gens_d == target_q) begin
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    assign q      = row_q;
    assign gens   = gens_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign stable = stable_q;

endmodule

// File: tb/tb_eca_engine.sv
// Directed bench for eca_engine at WIDTH=8: rule-90 steps, boundaries, stability stop, abort, load, reset.
module tb_eca_engine;

    localparam int WIDTH = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             load;
    logic [WIDTH-1:0] data;
    logic [7:0]       rule;
    logic [1:0]       bound;
    logic [CNT_W-1:0] gen_target;
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             stable;
    logic [CNT_W-1:0] gens;

    int n_checks = 0;
    int n_fail   = 0;

    eca_engine #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .data       (data),
        .rule       (rule),
        .bound      (bound),
        .gen_target (gen_target),
        .start      (start),
        .abort      (abort),
        .q          (q),
        .busy       (busy),
        .done       (done),
        .stable     (stable),
        .gens       (gens)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] d);
        load = 1'b1;
        data = d;
        tick();
        load = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] r, input logic [1:0] b, input logic [CNT_W-1:0] t);
        rule       = r;
        bound      = b;
        gen_target = t;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load  = 1'b1;
        data  = 8'hFF;
        tick();
        load  = 1'b0;
        tick();
        n_checks++;
        if (q !== 8'h00) begin n_fail++; $display("FAIL reset_q got=%h exp=00", q); end
        n_checks++;
        if (gens !== 16'd0) begin n_fail++; $display("FAIL reset_gens got=%0d exp=0", gens); end
        n_checks++;
        if ({busy, done, stable} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags got busy/done/stable=%b exp=000", {busy, done, stable});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_step();
        do_load(8'h10);
        do_start(8'h5A, 2'd0, 16'd1);
        n_checks++;
        if ({busy, done} !== 2'b10 || q !== 8'h10) begin
            n_fail++; $display("FAIL accept_edge got busy/done=%b q=%h exp=10 q=10", {busy, done}, q);
        end
        tick();
        n_checks++;
        if (q !== 8'h28) begin n_fail++; $display("FAIL step1_q got=%h exp=28", q); end
        n_checks++;
        if (gens !== 16'd1) begin n_fail++; $display("FAIL step1_gens got=%0d exp=1", gens); end
        n_checks++;
        if ({busy, done, stable} !== 3'b010) begin
            n_fail++; $display("FAIL step1_flags got busy/done/stable=%b exp=010", {busy, done, stable});
        end
    endtask

    task automatic test_boundaries();
        logic [WIDTH-1:0] tv_data [3] = '{8'h01, 8'h01, 8'h00};
        logic [1:0]       tv_bnd  [3] = '{2'd1, 2'd0, 2'd2};
        logic [WIDTH-1:0] tv_exp  [3] = '{8'h82, 8'h02, 8'h81};
        for (int k = 0; k < 3; k++) begin
            do_load(tv_data[k]);
            do_start(8'h5A, tv_bnd[k], 16'd1);
            tick();
            n_checks++;
            if (q !== tv_exp[k] || done !== 1'b1) begin
                n_fail++;
                $display("FAIL boundary_%0d got q=%h done=%b exp q=%h done=1", tv_bnd[k], q, done, tv_exp[k]);
            end
        end
    endtask

    task automatic test_stable();
        do_load(8'hFF);
        do_start(8'h00, 2'd0, 16'd3);
        tick();
        n_checks++;
        if (q !== 8'h00 || gens !== 16'd1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL stable_step1 got q=%h gens=%0d busy=%b exp q=00 gens=1 busy=1", q, gens, busy);
        end
        tick();
        n_checks++;
        if ({busy, done, stable} !== 3'b011) begin
            n_fail++; $display("FAIL stable_flags got busy/done/stable=%b exp=011", {busy, done, stable});
        end
        n_checks++;
        if (q !== 8'h00 || gens !== 16'd1) begin
            n_fail++; $display("FAIL stable_hold got q=%h gens=%0d exp q=00 gens=1", q, gens);
        end
    endtask

    task automatic test_abort_load();
        do_load(8'h10);
        do_start(8'h5A, 2'd0, 16'd10);
        tick();
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        // Rule 90 from 0x10: 28, 44, AA; the abort edge must not add a fourth step.
        n_checks++;
        if (q !== 8'hAA || gens !== 16'd3) begin
            n_fail++; $display("FAIL abort_hold got q=%h gens=%0d exp q=AA gens=3", q, gens);
        end
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++; $display("FAIL abort_flags got busy/done=%b exp=00", {busy, done});
        end
        tick();
        n_checks++;
        if (q !== 8'hAA) begin n_fail++; $display("FAIL abort_idle_q got=%h exp=AA", q); end
        load       = 1'b1;
        data       = 8'hA5;
        start      = 1'b1;
        gen_target = 16'd5;
        tick();
        load  = 1'b0;
        start = 1'b0;
        tick();
        n_checks++;
        if (q !== 8'hA5 || gens !== 16'd0 || {busy, done} !== 2'b00) begin
            n_fail++; $display("FAIL load_beats_start got q=%h gens=%0d busy/done=%b exp q=A5 gens=0 00", q, gens, {busy, done});
        end
    endtask

    task automatic test_zero_target_and_start_in_run();
        do_start(8'h5A, 2'd0, 16'd0);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || q !== 8'hA5 || gens !== 16'd0) begin
            n_fail++; $display("FAIL zero_target got done=%b busy=%b q=%h gens=%0d exp 1 0 A5 0", done, busy, q, gens);
        end
        do_load(8'h10);
        do_start(8'h5A, 2'd0, 16'd4);
        tick();
        do_start(8'h00, 2'd2, 16'd1);
        n_checks++;
        if (busy !== 1'b1 || gens !== 16'd2 || q !== 8'h44) begin
            n_fail++; $display("FAIL start_in_run got busy=%b gens=%0d q=%h exp 1 2 44", busy, gens, q);
        end
        tick();
        tick();
        n_checks++;
        if (done !== 1'b1 || gens !== 16'd4 || q !== 8'h01 || stable !== 1'b0) begin
            n_fail++; $display("FAIL run4_end got done=%b gens=%0d q=%h stable=%b exp 1 4 01 0", done, gens, q, stable);
        end
    endtask

    task automatic test_reset_mid_run();
        do_load(8'h10);
        do_start(8'h5A, 2'd1, 16'd10);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (q !== 8'h00 || gens !== 16'd0 || {busy, done, stable} !== 3'b000) begin
            n_fail++; $display("FAIL reset_mid_run got q=%h gens=%0d flags=%b exp 00 0 000", q, gens, {busy, done, stable});
        end
        load = 1'b1;
        data = 8'hFF;
        tick();
        load = 1'b0;
        n_checks++;
        if (q !== 8'h00) begin n_fail++; $display("FAIL reset_beats_load got q=%h exp=00", q); end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0 || q !== 8'h00) begin
            n_fail++; $display("FAIL post_reset_idle got busy=%b q=%h exp 0 00", busy, q);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        load       = 1'b0;
        data       = '0;
        rule       = '0;
        bound      = '0;
        gen_target = '0;
        start      = 1'b0;
        abort      = 1'b0;
        test_reset();
        test_single_step();
        test_boundaries();
        test_stable();
        test_abort_load();
        test_zero_target_and_start_in_run();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
